// File: rtl/relu_maxpool2_stream.sv
// 2x2 stride-2 max-pool with optional ReLU over a raster-ordered, channel-packed pixel stream.
// Horizontal pairs are reduced through a hold register; vertical pairs through a half-width line buffer.
module relu_maxpool2_stream #(
  parameter int N          = 16,
  parameter int CHANNEL    = 32,
  parameter int INPUT_SIZE = 6,
  parameter int RELU       = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 input_vld,
  input  logic [CHANNEL*N-1:0] input_din,
  output logic [CHANNEL*N-1:0] pool_dout,
  output logic                 pool_dout_vld,
  output logic                 pool_dout_end
);

  localparam int W    = CHANNEL * N;
  localparam int HALF = INPUT_SIZE / 2;
  localparam int CW   = (INPUT_SIZE > 2) ? $clog2(INPUT_SIZE) : 1;
  localparam int HW   = (HALF > 1) ? $clog2(HALF) : 1;

  logic [CW-1:0] col_q, col_d;
  logic [CW-1:0] row_q, row_d;
  logic [W-1:0]  hold_q, hold_d;
  logic [W-1:0]  dout_q, dout_d;
  logic          vld_q, vld_d;
  logic          end_q, end_d;

  logic [W-1:0]  linebuf_q [HALF];
  logic          lb_we;
  logic [HW-1:0] lb_idx;
  logic [W-1:0]  hmax;
  logic [W-1:0]  pooled;
  logic          last_col;
  logic          last_row;

  function automatic logic [N-1:0] smax(input logic [N-1:0] a, input logic [N-1:0] b);
    return ($signed(a) >= $signed(b)) ? a : b;
  endfunction

  assign lb_idx   = HW'(col_q >> 1);
  assign last_col = (col_q == CW'(INPUT_SIZE - 1));
  assign last_row = (row_q == CW'(INPUT_SIZE - 1));

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    col_d  = col_q;
    row_d  = row_q;
    hold_d = hold_q;
    dout_d = dout_q;
    vld_d  = 1'b0;
    end_d  = end_q;
    lb_we  = 1'b0;
    hmax   = '0;
    pooled = '0;

    for (int c = 0; c < CHANNEL; c++) begin
      hmax[c*N +: N]   = smax(hold_q[c*N +: N], input_din[c*N +: N]);
      pooled[c*N +: N] = smax(linebuf_q[lb_idx][c*N +: N], hmax[c*N +: N]);
      if (RELU != 0 && pooled[c*N + N - 1]) pooled[c*N +: N] = '0;
    end

    if (input_vld) begin
      if (!col_q[0]) begin
        hold_d = input_din;
      end else if (!row_q[0]) begin
        lb_we = 1'b1;
      end else begin
        dout_d = pooled;
        vld_d  = 1'b1;
      end

      // The first beat of a frame drops end; the last beat raises it together with the final vld.
      if (col_q == '0 && row_q == '0) end_d = 1'b0;

      if (last_col) begin
        col_d = '0;
        if (last_row) begin
          row_d = '0;
          end_d = 1'b1;
        end else begin
          row_d = row_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state flops use non-blocking assignments so all of them update from the same pre-edge values.
    if (!rst_n) begin
      col_q  <= '0;
      row_q  <= '0;
      hold_q <= '0;
      dout_q <= '0;
      vld_q  <= 1'b0;
      end_q  <= 1'b1;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      hold_q <= hold_d;
      dout_q <= dout_d;
      vld_q  <= vld_d;
      end_q  <= end_d;
    end
  end

  // NOTE: the line buffer has no reset; each entry is written on an even row before the odd row reads it.
  always_ff @(posedge clk) begin
    if (lb_we) linebuf_q[lb_idx] <= hmax;
  end

  assign pool_dout     = dout_q;
  assign pool_dout_vld = vld_q;
  assign pool_dout_end = end_q;

endmodule
